// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_pkg
//  Brief    : Shared types and defaults for the systolic array blocks
//             (edge feeders and processing cells).
//  Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

  // Default operand width used by feeders and cells.
  localparam int DEF_BIT_WIDTH = 8;

  // Feeder sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } feeder_state_e;

  // A lane is delayed by its own index, so lane `lane` carries operand
  // (step - lane) while that difference lies inside the K-long tile row.
  function automatic bit lane_active(input int step, input int lane, input int k);
    return (step >= lane) && (step < lane + k);
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_feeder
//  Brief    : Buffers an N x K operand tile and streams it skewed onto the
//             N edge lanes of a systolic array (lane i delayed i cycles).
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int N         = 4,
  parameter int K         = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [$clog2(N)-1:0]   wr_lane,
  input  logic [$clog2(K)-1:0]   wr_idx,
  input  logic [BIT_WIDTH-1:0]   wr_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [N-1:0]           en_out,
  output logic [N*BIT_WIDTH-1:0] data_out
);

  // Number of skewed steps needed to drain a whole tile.
  localparam int T      = K + N - 1;
  localparam int CNT_W  = $clog2(K + N);
  localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(T - 1);

  feeder_state_e          state_q, state_d;
  logic [CNT_W-1:0]       step_q, step_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [N-1:0]           en_q, en_d;
  logic [N*BIT_WIDTH-1:0] data_q, data_d;

  logic [BIT_WIDTH-1:0]   tile_q [N][K];
  logic [BIT_WIDTH-1:0]   tile_d [N][K];

  // Tile buffer update: only idle writes land; start and reset both win.
  always_comb begin
    tile_d = tile_q;
    if (reset && wr_en && !start && (state_q == ST_IDLE)) begin
      tile_d[wr_lane][wr_idx] = wr_data;
    end
  end

  // Next-state, step counter and registered lane outputs for the next cycle.
  always_comb begin
    int                   rel;
    logic [IDX_W-1:0]     lane_idx;

    state_d  = state_q;
    step_d   = step_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    en_d     = '0;
    data_d   = '0;
    rel      = 0;
    lane_idx = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          step_d  = '0;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (step_q == T_LAST) begin
          // Last step already shown; hold the counter so it never wraps.
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          step_d = step_q + 1'b1;
          busy_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
    endcase

    // Lane values are computed for the step that becomes visible next.
    if (busy_d) begin
      for (int i = 0; i < N; i++) begin
        rel = int'(step_d) - i;
        if (lane_active(int'(step_d), i, K)) begin
          lane_idx                          = IDX_W'(rel);
          en_d[i]                           = 1'b1;
          data_d[i*BIT_WIDTH +: BIT_WIDTH]  = tile_q[i][lane_idx];
        end
      end
    end
  end

  // Control and output registers; reset aborts any stream silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_d;
      data_q  <= data_d;
    end
  end

  // Tile storage deliberately has no reset so a tile survives an abort.
  always_ff @(posedge clk) begin
    tile_q <= tile_d;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign en_out   = en_q;
  assign data_out = data_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_feeder
//  Brief    : Self-checking bench for systolic_feeder (N=4, K=4, T=7).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;

  localparam int BW = 8;
  localparam int N  = 4;
  localparam int K  = 4;
  localparam int T  = K + N - 1;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [1:0]    wr_lane;
  logic [1:0]    wr_idx;
  logic [BW-1:0] wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic [N-1:0]  en_out;
  logic [N*BW-1:0] data_out;

  logic          b_wr_en;
  logic [1:0]    b_wr_lane;
  logic [1:0]    b_wr_idx;
  logic [BW-1:0] b_wr_data;
  logic          b_start;
  logic          b_busy;
  logic          b_done;
  logic [N-1:0]  b_en_out;
  logic [N*BW-1:0] b_data_out;

  systolic_feeder #(.BIT_WIDTH(BW), .N(N), .K(K)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_lane(wr_lane),
    .wr_idx(wr_idx), .wr_data(wr_data), .start(start), .busy(busy),
    .done(done), .en_out(en_out), .data_out(data_out)
  );

  systolic_feeder #(.BIT_WIDTH(BW), .N(N), .K(K)) dut_b (
    .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_lane(b_wr_lane),
    .wr_idx(b_wr_idx), .wr_data(b_wr_data), .start(b_start), .busy(b_busy),
    .done(b_done), .en_out(b_en_out), .data_out(b_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference copy of the tile held by feeder A.
  logic [BW-1:0] mbuf [N][K];

  typedef struct {
    int          step;
    logic [3:0]  en;
    logic [31:0] data;
  } vec_t;
  vec_t skew_tab [T];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_en(input int t);
    logic [3:0] r = '0;
    for (int i = 0; i < N; i++) if (t >= i && t < i + K) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] exp_data(input int t);
    logic [31:0] r = '0;
    for (int i = 0; i < N; i++) if (t >= i && t < i + K) r[i*BW +: BW] = mbuf[i][t-i];
    return r;
  endfunction

  task automatic check_step(input string tag, input int t);
    chk($sformatf("%s s%0d busy", tag, t), 64'(busy), 64'd1);
    chk($sformatf("%s s%0d done", tag, t), 64'(done), 64'd0);
    chk($sformatf("%s s%0d en", tag, t), 64'(en_out), 64'(exp_en(t)));
    chk($sformatf("%s s%0d data", tag, t), 64'(data_out), 64'(exp_data(t)));
  endtask

  task automatic check_quiet(input string tag, input logic exp_done);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'(exp_done));
    chk({tag, " en"}, 64'(en_out), 64'd0);
    chk({tag, " data"}, 64'(data_out), 64'd0);
  endtask

  // Idle write to feeder A; the model follows.
  task automatic wr(input int l, input int j, input logic [BW-1:0] d);
    wr_en = 1'b1; wr_lane = 2'(l); wr_idx = 2'(j); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    mbuf[l][j] = d;
  endtask

  // Streams one tile from IDLE, optionally colliding a write with start,
  // writing during a step, or resetting at a step. Called at a negedge.
  task automatic run_tile(input string tag, input bit collide, input int wr_step, input int rst_step);
    start = 1'b1;
    if (collide) begin
      wr_en = 1'b1; wr_lane = 2'd1; wr_idx = 2'd0; wr_data = 8'd77;
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    for (int t = 0; t < T; t++) begin
      check_step(tag, t);
      if (t == wr_step) begin
        wr_en = 1'b1; wr_lane = 2'd0; wr_idx = 2'd0; wr_data = 8'd99;
      end
      if (t == rst_step) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_quiet({tag, " abort"}, 1'b0);
        @(negedge clk);
        check_quiet({tag, " post-abort"}, 1'b0);
        return;
      end
      @(negedge clk);
      wr_en = 1'b0;
    end
    check_quiet({tag, " done-cycle"}, 1'b1);
    @(negedge clk);
    check_quiet({tag, " idle"}, 1'b0);
  endtask

  initial begin
    int ndone;
    int dcyc;
    int acc;
    int nprod;

    skew_tab[0] = '{0, 4'b0001, 32'h0000_0001};
    skew_tab[1] = '{1, 4'b0011, 32'h0000_0B02};
    skew_tab[2] = '{2, 4'b0111, 32'h0015_0C03};
    skew_tab[3] = '{3, 4'b1111, 32'h1F16_0D04};
    skew_tab[4] = '{4, 4'b1110, 32'h2017_0E00};
    skew_tab[5] = '{5, 4'b1100, 32'h2118_0000};
    skew_tab[6] = '{6, 4'b1000, 32'h2200_0000};

    // Reset with start and a write pending: reset must win.
    reset = 1'b0; start = 1'b1; wr_en = 1'b0; wr_lane = '0; wr_idx = '0; wr_data = '0;
    b_wr_en = 1'b0; b_wr_lane = '0; b_wr_idx = '0; b_wr_data = '0; b_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_quiet("reset", 1'b0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_quiet("after-reset", 1'b0);

    // Skew check against a hand-computed table.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < K; j++) wr(i, j, 8'(10 * i + j + 1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < T; r++) begin
      chk($sformatf("skew s%0d busy", skew_tab[r].step), 64'(busy), 64'd1);
      chk($sformatf("skew s%0d en", skew_tab[r].step), 64'(en_out), 64'(skew_tab[r].en));
      chk($sformatf("skew s%0d data", skew_tab[r].step), 64'(data_out), 64'(skew_tab[r].data));
      @(negedge clk);
    end
    ndone = 0; dcyc = -1;
    for (int c = T; c < T + 4; c++) begin
      if (done) begin ndone++; dcyc = c; end
      @(negedge clk);
    end
    chk("skew done count", 64'(ndone), 64'd1);
    chk("skew done delay", 64'(dcyc), 64'(T));

    // Writes during RUN are dropped; restart replays the original tile.
    run_tile("wrblk", 1'b0, 2, -1);
    run_tile("wrblk-re", 1'b0, -1, -1);

    // Start and write in the same idle cycle: start wins.
    run_tile("collide", 1'b0 | 1'b1, -1, -1);

    // Abort at step 3, then a reset with a pending write, then replay.
    run_tile("rstmid", 1'b0, -1, 3);
    reset = 1'b0; wr_en = 1'b1; wr_lane = 2'd2; wr_idx = 2'd2; wr_data = 8'hEE;
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b0;
    run_tile("replay", 1'b0, -1, -1);

    // start held for 12 edges: one tile, done, idle, then a second tile.
    start = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c <= 6) check_step("hold1", c);
      else if (c == 7) check_quiet("hold done1", 1'b1);
      else if (c == 8) check_quiet("hold idle", 1'b0);
      else if (c <= 15) check_step("hold2", c - 9);
      else if (c == 16) check_quiet("hold done2", 1'b1);
      else check_quiet("hold end", 1'b0);
      if (c == 11) start = 1'b0;
    end

    // Randomised tiles against the model.
    for (int it = 0; it < 6; it++) begin
      int nw = $urandom_range(1, 8);
      for (int w = 0; w < nw; w++)
        wr($urandom_range(0, N - 1), $urandom_range(0, K - 1), 8'($urandom));
      run_tile($sformatf("rand%0d", it), 1'($urandom_range(0, 1)), -1, -1);
    end

    // Two feeders into one MAC lane: all operands 2, four products of 4.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < K; j++) begin
        b_wr_en = 1'b1; b_wr_lane = 2'(i); b_wr_idx = 2'(j); b_wr_data = 8'd2;
        wr(i, j, 8'd2);
        b_wr_en = 1'b0;
      end
    start = 1'b1; b_start = 1'b1;
    acc = 0; nprod = 0;
    for (int c = 0; c < T + 2; c++) begin
      @(negedge clk);
      start = 1'b0; b_start = 1'b0;
      if (en_out[0] && b_en_out[0]) begin
        acc += int'(data_out[BW-1:0]) * int'(b_data_out[BW-1:0]);
        nprod++;
      end
    end
    chk("mac products", 64'(nprod), 64'd4);
    chk("mac out_c", 64'(acc), 64'd16);
    chk("mac b idle", 64'(b_busy | b_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
